bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using an iterative shift-and-add-3 (double dabble) datapath, one bit per clock. It replaces the purely combinational 8-bit converter in display paths where WIDTH is large enough that an unrolled chain would hurt timing. Valid/ready handshakes sit on both sides. Outputs also carry an overflow flag and a leading-zero blanking mask for seven-segment drivers.

---
 rtl/bin2bcd_seq.sv | 98 +++++++++
 tb/tb_bin2bcd_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with valid/ready on both sides, overflow flag and leading-zero blanking.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     adj;
  logic              ovf_r;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] blank_c;
  logic              zsuf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1))     state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Per-digit add-3 correction, applied before every shift.
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // A 1 leaving the top digit means the value exceeds DIGITS digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      ovf_r <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg <= bin;
          acc   <= '0;
          ovf_r <= 1'b0;
          cnt   <= CW'(WIDTH);
        end
        SHIFT: begin
          acc   <= {adj[AW-2:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          ovf_r <= ovf_r | adj[AW-1];
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // blank[k] is set while every digit from k upward is zero.
  always_comb begin
    blank_c = '0;
    zsuf    = 1'b1;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      zsuf               = zsuf & (acc[4*(DIGITS-i) +: 4] == 4'd0);
      blank_c[DIGITS-i]  = zsuf;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bcd       = out_valid ? acc : '0;
  assign ovf       = out_valid & ovf_r;
  assign blank     = (out_valid && !ovf_r) ? blank_c : '0;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three parameterisations driven through
// a shared stimulus path and checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] bin_w = '0;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [11:0] b0;
  logic [19:0] b1;
  logic [7:0]  b2;
  logic [2:0]  bl0;
  logic [4:0]  bl1;
  logic [1:0]  bl2;
  logic        ir_m, ov_m, of_m;
  logic [19:0] bcd_m;
  logic [4:0]  bl_m;

  typedef struct {
    int         s;
    int         v;
    logic [19:0] b;
    logic       o;
    logic [4:0] bl;
  } vec_t;

  vec_t dir_tab[9] = '{
    '{0, 255,   20'h00255, 1'b0, 5'b00000},
    '{0, 0,     20'h00000, 1'b0, 5'b00110},
    '{0, 9,     20'h00009, 1'b0, 5'b00110},
    '{0, 100,   20'h00100, 1'b0, 5'b00000},
    '{1, 65535, 20'h65535, 1'b0, 5'b00000},
    '{1, 10000, 20'h10000, 1'b0, 5'b00000},
    '{2, 99,    20'h00099, 1'b0, 5'b00000},
    '{2, 100,   20'h00000, 1'b1, 5'b00000},
    '{2, 255,   20'h00055, 1'b1, 5'b00000}
  };

  assign iv0 = iv && (sel == 0);
  assign iv1 = iv && (sel == 1);
  assign iv2 = iv && (sel == 2);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .bin(bin_w[7:0]),
    .out_valid(ov0), .out_ready(out_ready), .bcd(b0), .ovf(of0), .blank(bl0));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin(bin_w),
    .out_valid(ov1), .out_ready(out_ready), .bcd(b1), .ovf(of1), .blank(bl1));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bin(bin_w[7:0]),
    .out_valid(ov2), .out_ready(out_ready), .bcd(b2), .ovf(of2), .blank(bl2));

  always_comb begin
    case (sel)
      1: begin ir_m = ir1; ov_m = ov1; of_m = of1; bcd_m = b1;          bl_m = bl1;          end
      2: begin ir_m = ir2; ov_m = ov2; of_m = of2; bcd_m = {12'h0, b2}; bl_m = {3'b0, bl2};  end
      default: begin ir_m = ir0; ov_m = ov0; of_m = of0; bcd_m = {8'h0, b0}; bl_m = {2'b0, bl0}; end
    endcase
  end

  function automatic int wof(input int s);
    return (s == 1) ? 16 : 8;
  endfunction

  function automatic int dof(input int s);
    return (s == 0) ? 3 : (s == 1) ? 5 : 2;
  endfunction

  function automatic int vmax(input int s);
    return (s == 1) ? 65535 : 255;
  endfunction

  // Decimal reference: low d digits of v, overflow if v >= 10^d.
  function automatic void model(input int v, input int d, output logic [19:0] b,
                                output logic o, output logic [4:0] bl);
    int lim, r, p;
    lim = 1;
    for (int i = 0; i < d; i++) lim *= 10;
    o  = (v >= lim);
    r  = v % lim;
    b  = '0;
    bl = '0;
    p  = 1;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'((r / p) % 10);
      if (i > 0) bl[i] = !o && (r < p);
      p *= 10;
    end
  endfunction

  // Drive one operand with out_ready high; return after the release edge.
  task automatic run_conv(input int s, input int v, output int lat, output logic [19:0] b,
                          output logic o, output logic [4:0] bl, output logic busy_rdy,
                          output logic post_ok);
    sel       = s;
    out_ready = 1'b1;
    busy_rdy  = 1'b0;
    bin_w     = 16'(v);
    iv        = 1'b1;
    @(posedge clk); #1;
    iv    = 1'b0;
    bin_w = 16'($urandom);
    lat   = 0;
    while (!ov_m && lat < 200) begin
      busy_rdy = busy_rdy | ir_m;
      @(posedge clk); #1;
      lat++;
    end
    b = bcd_m; o = of_m; bl = bl_m;
    busy_rdy = busy_rdy | ir_m;
    @(posedge clk); #1;
    post_ok = ir_m && !ov_m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if (ir_m !== 1'b1 || ov_m !== 1'b0 || bcd_m !== 20'h0 || of_m !== 1'b0 || bl_m !== 5'b0) begin
        n_bad++;
        $display("FAIL reset[%0d] got rdy=%b vld=%b bcd=%h ovf=%b blank=%b want rdy=1 vld=0 bcd=0 ovf=0 blank=0",
                 s, ir_m, ov_m, bcd_m, of_m, bl_m);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sel = 0; #1;
    n_cmp++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset got rdy=%b vld=%b want rdy=1 vld=0", ir_m, ov_m);
    end
  endtask

  task automatic test_directed();
    int lat; logic [19:0] b; logic o; logic [4:0] bl; logic busy, post;
    for (int i = 0; i < 9; i++) begin
      run_conv(dir_tab[i].s, dir_tab[i].v, lat, b, o, bl, busy, post);
      n_cmp++;
      if (lat != wof(dir_tab[i].s)) begin
        n_bad++;
        $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, wof(dir_tab[i].s));
      end
      n_cmp++;
      if (b !== dir_tab[i].b || o !== dir_tab[i].o || bl !== dir_tab[i].bl) begin
        n_bad++;
        $display("FAIL dir_result[%0d] bin=%0d got bcd=%h ovf=%b blank=%b want bcd=%h ovf=%b blank=%b",
                 i, dir_tab[i].v, b, o, bl, dir_tab[i].b, dir_tab[i].o, dir_tab[i].bl);
      end
      n_cmp++;
      if (busy !== 1'b0 || post !== 1'b1) begin
        n_bad++;
        $display("FAIL dir_ready[%0d] got busy_rdy=%b release_ok=%b want 0 and 1", i, busy, post);
      end
    end
  endtask

  task automatic test_random();
    int v, lat; logic [19:0] b, eb; logic o, eo; logic [4:0] bl, ebl; logic busy, post;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 20; k++) begin
        v = int'($urandom_range(0, vmax(s)));
        model(v, dof(s), eb, eo, ebl);
        run_conv(s, v, lat, b, o, bl, busy, post);
        n_cmp++;
        if (b !== eb || o !== eo || bl !== ebl || lat != wof(s)) begin
          n_bad++;
          $display("FAIL rand[%0d] bin=%0d got bcd=%h ovf=%b blank=%b lat=%0d want bcd=%h ovf=%b blank=%b lat=%0d",
                   s, v, b, o, bl, lat, eb, eo, ebl, wof(s));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, v, lat; logic [19:0] b, eb; logic o, eo; logic [4:0] bl, ebl; logic busy, post;
    for (int s = 0; s < 3; s++) begin
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
        v = int'($urandom_range(0, vmax(s)));
        model(v, dof(s), eb, eo, ebl);
        run_conv(s, v, lat, b, o, bl, busy, post);
        n_cmp++;
        if (b !== eb || o !== eo || bl !== ebl) begin
          n_bad++;
          $display("FAIL b2b_result[%0d] bin=%0d got bcd=%h ovf=%b blank=%b want bcd=%h ovf=%b blank=%b",
                   s, v, b, o, bl, eb, eo, ebl);
        end
      end
      n_cmp++;
      if (cyc - c0 != 4 * (wof(s) + 2)) begin
        n_bad++;
        $display("FAIL b2b_cycles[%0d] got %0d want %0d", s, cyc - c0, 4 * (wof(s) + 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int v, n; logic [19:0] eb; logic eo; logic [4:0] ebl;
    sel = 0;
    v = int'($urandom_range(100, 255));
    model(v, 3, eb, eo, ebl);
    out_ready = 1'b0;
    bin_w = 16'(v);
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    n = 0;
    while (!ov_m && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL bp_latency got %0d want 8", n);
    end
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (ov_m !== 1'b1 || ir_m !== 1'b0 || bcd_m !== eb || of_m !== eo || bl_m !== ebl) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b bcd=%h ovf=%b blank=%b want vld=1 rdy=0 bcd=%h ovf=%b blank=%b",
                 c, ov_m, ir_m, bcd_m, of_m, bl_m, eb, eo, ebl);
      end
      if (c < 5) begin
        iv = c[0];
        bin_w = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    n_cmp++;
    if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", ov_m, ir_m);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic seen; logic [19:0] b; logic o; logic [4:0] bl; logic busy, post;
    sel = 0;
    out_ready = 1'b1;
    bin_w = 16'd200;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (ir_m !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy got rdy=%b want 0", ir_m);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0 || bcd_m !== 20'h0 || of_m !== 1'b0 || bl_m !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_reset got rdy=%b vld=%b bcd=%h ovf=%b blank=%b want rdy=1 vld=0 bcd=0 ovf=0 blank=0",
               ir_m, ov_m, bcd_m, of_m, bl_m);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      seen = seen | ov_m;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_valid got out_valid seen=%b want 0", seen);
    end
    run_conv(0, 42, lat, b, o, bl, busy, post);
    n_cmp++;
    if (b !== 20'h00042 || o !== 1'b0 || bl !== 5'b00100 || lat != 8) begin
      n_bad++;
      $display("FAIL abort_next got bcd=%h ovf=%b blank=%b lat=%0d want bcd=00042 ovf=0 blank=00100 lat=8",
               b, o, bl, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
